perceptron_train_seq: RTL and testbench

- Sequencing FSM for the perceptron training datapath. It drives the datapath's ld_/clr_ strobes for the sample index N, epoch counter Ep, weights w and error e.
- It consumes the datapath status flags Epm, Nm and err_nz.
- Adds a start/done handshake, per-epoch error counting and early stop on convergence.
- Sits between the top-level button/clock-divider logic and the datapath, on the divided training clock.

---
 rtl/perceptron_train_seq_if.sv | 59 +++++
 rtl/perceptron_train_seq.sv | 166 ++++++++++++++++
 tb/tb_perceptron_train_seq.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_train_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : perceptron_train_seq_if                            |
// | Description : Handshake, status and datapath strobe/flag bundle  |
// |               for the perceptron training sequencer. The step    |
// |               input exists only when STEP_MODE_EN is defined.    |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
interface perceptron_train_seq_if #(
  parameter int ERR_W = 4
);
  // Handshake and datapath status flags into the sequencer
  logic             start;
  logic             Epm;
  logic             Nm;
  logic             err_nz;
`ifdef STEP_MODE_EN
  logic             step;
`endif
  // Datapath strobes out of the sequencer
  logic             ld_N;
  logic             clr_N;
  logic             ld_Ep;
  logic             clr_Ep;
  logic             ld_w;
  logic             clr_w;
  logic             ld_e;
  logic             clr_e;
  // Run status
  logic             busy;
  logic             done;
  logic             converged;
  logic [ERR_W-1:0] err_cnt;

`ifdef STEP_MODE_EN
  modport master (
    input  start, Epm, Nm, err_nz, step,
    output ld_N, clr_N, ld_Ep, clr_Ep, ld_w, clr_w, ld_e, clr_e,
    output busy, done, converged, err_cnt
  );
  modport slave (
    output start, Epm, Nm, err_nz, step,
    input  ld_N, clr_N, ld_Ep, clr_Ep, ld_w, clr_w, ld_e, clr_e,
    input  busy, done, converged, err_cnt
  );
`else
  modport master (
    input  start, Epm, Nm, err_nz,
    output ld_N, clr_N, ld_Ep, clr_Ep, ld_w, clr_w, ld_e, clr_e,
    output busy, done, converged, err_cnt
  );
  modport slave (
    output start, Epm, Nm, err_nz,
    input  ld_N, clr_N, ld_Ep, clr_Ep, ld_w, clr_w, ld_e, clr_e,
    input  busy, done, converged, err_cnt
  );
`endif
endinterface
`default_nettype wire

// File: rtl/perceptron_train_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : perceptron_train_seq                               |
// | Description : Sequencing FSM for the perceptron training         |
// |               datapath: start/done handshake, per-epoch error    |
// |               counting and early stop on a zero-error epoch.     |
// |               Optional macro STEP_MODE_EN adds single-sample     |
// |               stepping on rising edges of the step input.        |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module perceptron_train_seq #(
  parameter int ERR_W    = 4,
  parameter int INIT_CYC = 1
) (
  input  wire                      clk,
  input  wire                      rst,
  perceptron_train_seq_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_CALC   = 3'd2,
    S_UPD    = 3'd3,
    S_NEXT   = 3'd4,
    S_EP_END = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [3:0]       c_INIT_LOAD = 4'(INIT_CYC);
  localparam logic [ERR_W-1:0] c_ERR_MAX   = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_init_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_converged;
  logic             w_adv;
  logic             w_enter_init;
  logic             w_ld_N, w_clr_N, w_ld_Ep, w_clr_Ep;
  logic             w_ld_w, w_clr_w, w_ld_e, w_clr_e;

`ifdef STEP_MODE_EN
  logic r_step_prev;

  // Previous step level for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) r_step_prev <= 1'b0;
    else     r_step_prev <= bus.step;
  end

  assign w_adv = bus.step & ~r_step_prev;
`else
  assign w_adv = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and strobe decode
  always_comb begin
    w_state_next = r_state;
    w_ld_N   = 1'b0;
    w_clr_N  = 1'b0;
    w_ld_Ep  = 1'b0;
    w_clr_Ep = 1'b0;
    w_ld_w   = 1'b0;
    w_clr_w  = 1'b0;
    w_ld_e   = 1'b0;
    w_clr_e  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_INIT;
      end
      S_INIT: begin
        w_clr_N  = 1'b1;
        w_clr_Ep = 1'b1;
        w_clr_w  = 1'b1;
        w_clr_e  = 1'b1;
        if (r_init_cnt <= 4'd1) w_state_next = S_CALC;
      end
      S_CALC: begin
        w_ld_e       = 1'b1;
        w_state_next = S_UPD;
      end
      S_UPD: begin
        w_ld_w       = bus.err_nz;
        w_state_next = S_NEXT;
      end
      S_NEXT: begin
        if (w_adv) begin
          if (!bus.Nm) begin
            w_ld_N       = 1'b1;
            w_state_next = S_CALC;
          end else begin
            w_state_next = S_EP_END;
          end
        end
      end
      S_EP_END: begin
        // Zero-error epoch wins over the last-epoch stop
        if (r_err_cnt == '0 || bus.Epm) begin
          w_state_next = S_DONE;
        end else begin
          w_ld_Ep      = 1'b1;
          w_clr_N      = 1'b1;
          w_state_next = S_CALC;
        end
      end
      S_DONE: begin
        if (bus.start) w_state_next = S_INIT;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_enter_init = (w_state_next == S_INIT) && (r_state != S_INIT);

  // INIT hold counter, loaded on every entry to INIT
  always_ff @(posedge clk) begin
    if (rst)                     r_init_cnt <= 4'd0;
    else if (w_enter_init)       r_init_cnt <= c_INIT_LOAD;
    else if (r_state == S_INIT)  r_init_cnt <= r_init_cnt - 4'd1;
  end

  // Per-epoch error counter, saturating; holds through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_enter_init || r_state == S_INIT) begin
      r_err_cnt <= '0;
    end else if (r_state == S_UPD && bus.err_nz && r_err_cnt != c_ERR_MAX) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end else if (r_state == S_EP_END && w_ld_Ep) begin
      r_err_cnt <= '0;
    end
  end

  // Convergence flag, decided at the end of the final epoch
  always_ff @(posedge clk) begin
    if (rst)                   r_converged <= 1'b0;
    else if (w_enter_init)     r_converged <= 1'b0;
    else if (r_state == S_EP_END && w_state_next == S_DONE)
      r_converged <= (r_err_cnt == '0);
  end

  // Strobes are masked while rst is high so an aborted cycle never
  // commits a datapath update on the reset edge.
  assign bus.ld_N      = w_ld_N   & ~rst;
  assign bus.clr_N     = w_clr_N  & ~rst;
  assign bus.ld_Ep     = w_ld_Ep  & ~rst;
  assign bus.clr_Ep    = w_clr_Ep & ~rst;
  assign bus.ld_w      = w_ld_w   & ~rst;
  assign bus.clr_w     = w_clr_w  & ~rst;
  assign bus.ld_e      = w_ld_e   & ~rst;
  assign bus.clr_e     = w_clr_e  & ~rst;
  assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.converged = r_converged;
  assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_train_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_perceptron_train_seq                            |
// | Description : Directed self-checking bench for the perceptron    |
// |               training sequencer with a small datapath model.    |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_perceptron_train_seq;

  localparam int ERR_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  perceptron_train_seq_if #(.ERR_W(ERR_W)) bus ();

  perceptron_train_seq #(.ERR_W(ERR_W), .INIT_CYC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Datapath model: sample index, epoch counter, error register
  int         s_num   = 4;
  int         epocas  = 1;
  logic [7:0] err_pat = 8'h00;
  int         n_idx   = 0;
  int         ep_idx  = 0;
  logic       e_reg   = 1'b0;

  always @(posedge clk) begin
    if (bus.clr_N)       n_idx  <= 0;
    else if (bus.ld_N)   n_idx  <= n_idx + 1;
    if (bus.clr_Ep)      ep_idx <= 0;
    else if (bus.ld_Ep)  ep_idx <= ep_idx + 1;
    if (bus.clr_e)       e_reg  <= 1'b0;
    else if (bus.ld_e)   e_reg  <= err_pat[n_idx & 7];
  end

  assign bus.Nm     = (n_idx == s_num - 1);
  assign bus.Epm    = (ep_idx == epocas - 1);
  assign bus.err_nz = e_reg;

  // Strobe pulse counters and mutual-exclusion monitor
  int n_lde = 0, n_ldw = 0, n_ldN = 0, n_ldEp = 0, n_viol = 0;

  always @(negedge clk) begin
    n_lde  <= n_lde  + int'(bus.ld_e);
    n_ldw  <= n_ldw  + int'(bus.ld_w);
    n_ldN  <= n_ldN  + int'(bus.ld_N);
    n_ldEp <= n_ldEp + int'(bus.ld_Ep);
    if ((bus.ld_N && bus.clr_N) || (int'(bus.ld_e) + int'(bus.ld_w) + int'(bus.ld_N) > 1))
      n_viol <= n_viol + 1;
  end

  logic [10+ERR_W:0] obs;
  assign obs = {bus.ld_N, bus.clr_N, bus.ld_Ep, bus.clr_Ep, bus.ld_w, bus.clr_w,
                bus.ld_e, bus.clr_e, bus.busy, bus.done, bus.converged, bus.err_cnt};

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout: done=%0b required=1", name, bus.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: outputs=%h required=0", c, obs);
      end
    end
  endtask

  // 4 samples, no errors, single allowed epoch (Epm and zero errors together)
  task automatic test_converge();
    logic [8:0] exp_v, act_v;
    bit clr, lde, ldn, dn;
    s_num = 4; epocas = 1; err_pat = 8'h00;
    pulse_start();
    for (int c = 1; c <= 15; c++) begin
      if (c > 1) @(negedge clk);
      clr = (c == 1);
      lde = (c == 2 || c == 5 || c == 8 || c == 11);
      ldn = (c == 4 || c == 7 || c == 10);
      dn  = (c == 15);
      exp_v = {clr, clr, clr, clr, lde, ldn, 1'b0, 1'b0, dn};
      act_v = {bus.clr_N, bus.clr_Ep, bus.clr_w, bus.clr_e, bus.ld_e, bus.ld_N,
               bus.ld_w, bus.ld_Ep, bus.done};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL converge_t0+%0d: strobes=%b required=%b", c, act_v, exp_v);
      end
    end
    checks++;
    if (bus.converged !== 1'b1 || bus.err_cnt !== '0) begin
      failures++;
      $display("FAIL converge_result: converged=%0b err_cnt=%0d required 1/0",
               bus.converged, bus.err_cnt);
    end
  endtask

  // 3 samples, error on sample 2 every epoch, 3 epochs allowed
  task automatic test_no_converge();
    int b_ldEp, b_ldw, b_lde;
    s_num = 3; epocas = 3; err_pat = 8'b0000_0010;
    b_ldEp = n_ldEp; b_ldw = n_ldw; b_lde = n_lde;
    pulse_start();
    wait_done("noconv");
    checks++;
    if (n_ldEp - b_ldEp !== 2) begin
      failures++;
      $display("FAIL noconv_ldEp: pulses=%0d required=2", n_ldEp - b_ldEp);
    end
    checks++;
    if (n_ldw - b_ldw !== 3) begin
      failures++;
      $display("FAIL noconv_ldw: pulses=%0d required=3", n_ldw - b_ldw);
    end
    checks++;
    if (n_lde - b_lde !== 9) begin
      failures++;
      $display("FAIL noconv_lde: pulses=%0d required=9", n_lde - b_lde);
    end
    checks++;
    if (bus.converged !== 1'b0 || bus.err_cnt !== 2'd1) begin
      failures++;
      $display("FAIL noconv_result: converged=%0b err_cnt=%0d required 0/1",
               bus.converged, bus.err_cnt);
    end
  endtask

  // 6 erroneous samples into a 2-bit counter, last epoch
  task automatic test_saturation();
    int b_ldw;
    s_num = 6; epocas = 1; err_pat = 8'h3F;
    b_ldw = n_ldw;
    pulse_start();
    wait_done("sat");
    checks++;
    if (n_ldw - b_ldw !== 6) begin
      failures++;
      $display("FAIL sat_ldw: pulses=%0d required=6", n_ldw - b_ldw);
    end
    checks++;
    if (bus.err_cnt !== 2'd3 || bus.converged !== 1'b0) begin
      failures++;
      $display("FAIL sat_result: err_cnt=%0d converged=%0b required 3/0",
               bus.err_cnt, bus.converged);
    end
  endtask

  // start held high across DONE: retrain after a single DONE cycle
  task automatic test_back_to_back();
    bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.clr_N, bus.done, bus.converged, bus.err_cnt} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL b2b_entry: clr_N=%0b done=%0b conv=%0b err_cnt=%0d required 1/0/0/0",
               bus.clr_N, bus.done, bus.converged, bus.err_cnt);
    end
    wait_done("b2b");
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.clr_N !== 1'b1) begin
      failures++;
      $display("FAIL b2b_one_done_cycle: done=%0b clr_N=%0b required 0/1",
               bus.done, bus.clr_N);
    end
    bus.start = 1'b0;
  endtask

  // Reset while in UPD with err_nz=1 (run still in progress from above)
  task automatic test_abort();
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.ld_w) got = 1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL abort_reach_upd: ld_w=%0b required=1", bus.ld_w);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ld_w !== 1'b0) begin
      failures++;
      $display("FAIL abort_ldw_masked: ld_w=%0b required=0", bus.ld_w);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL abort_idle: outputs=%h required=0", obs);
    end
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL abort_after: outputs=%h required=0", obs);
    end
  endtask

`ifdef STEP_MODE_EN
  task automatic test_step();
    s_num = 2; epocas = 1; err_pat = 8'h00;
    bus.step = 1'b0;
    pulse_start();
    repeat (3) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (obs[10+ERR_W:3+ERR_W] !== 8'h00 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL step_park cyc%0d: strobes=%b busy=%0b required 0/1",
                 c, obs[10+ERR_W:3+ERR_W], bus.busy);
      end
      @(negedge clk);
    end
    bus.step = 1'b1;
    #1;
    checks++;
    if (bus.ld_N !== 1'b1) begin
      failures++;
      $display("FAIL step_ldN: ld_N=%0b required=1", bus.ld_N);
    end
    @(negedge clk);
    checks++;
    if (bus.ld_e !== 1'b1 || bus.ld_N !== 1'b0) begin
      failures++;
      $display("FAIL step_calc: ld_e=%0b ld_N=%0b required 1/0", bus.ld_e, bus.ld_N);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.step = 1'b0;
  endtask
`endif

  task automatic test_exclusion();
    checks++;
    if (n_viol !== 0) begin
      failures++;
      $display("FAIL strobe_exclusion: violations=%0d required=0", n_viol);
    end
  endtask

  initial begin
    bus.start = 1'b0;
`ifdef STEP_MODE_EN
    bus.step = 1'b0;
`endif
    test_reset();
`ifdef STEP_MODE_EN
    test_step();
`else
    test_converge();
    test_no_converge();
    test_saturation();
    test_back_to_back();
    test_abort();
`endif
    test_exclusion();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
